// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding the 4-bit two-output ALU, with a registered
// result slot and an out2 == ~out1 invariant checker.
module alu_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_a,
  input  logic [W-1:0]                 in_b,
  input  logic [W-1:0]                 in_op,
  output logic [W-1:0]                 alu_a,
  output logic [W-1:0]                 alu_b,
  output logic [W-1:0]                 alu_op,
  input  logic [W-1:0]                 alu_out1,
  input  logic [W-1:0]                 alu_out2,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2*W-1:0]               res_data,
  output logic                         res_err,
  output logic                         err_sticky,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 3 * W;

  logic [EW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_res_valid;
  logic [2*W-1:0] r_res_data;
  logic           r_res_err;
  logic           r_err_sticky;

  logic           w_push;
  logic           w_pop;
  logic           w_nonempty;
  logic           w_slot_free;
  logic           w_bad;
  logic [EW-1:0]  w_head;

  assign in_ready    = (r_count < CW'(DEPTH));
  assign w_push      = in_valid & in_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_slot_free = ~r_res_valid | res_ready;
  assign w_pop       = w_nonempty & w_slot_free;
  assign w_bad       = (alu_out2 != ~alu_out1);
  assign w_head      = r_mem[r_rd_ptr];

  // Empty queue presents zeros rather than a stale entry
  assign alu_a  = w_nonempty ? w_head[EW-1 -: W]  : '0;
  assign alu_b  = w_nonempty ? w_head[2*W-1 -: W] : '0;
  assign alu_op = w_nonempty ? w_head[W-1:0]      : '0;

  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;
  assign err_sticky = r_err_sticky;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b, in_op};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop) begin
        r_res_data  <= {alu_out1, alu_out2};
        r_res_err   <= w_bad;
        r_res_valid <= 1'b1;
      end else if (res_ready & r_res_valid) begin
        r_res_valid <= 1'b0;
      end
      r_err_sticky <= r_err_sticky | (w_pop & w_bad);
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue with a behavioural ALU model;
// opcodes with op[3:2] == 2'b11 make the ALU return out2 == out1.
module tb_alu_cmd_queue;

  localparam int W = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic [W-1:0]   in_op = '0;
  logic [W-1:0]   alu_a, alu_b, alu_op;
  logic [W-1:0]   alu_out1, alu_out2;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [2*W-1:0] res_data;
  logic           res_err;
  logic           err_sticky;
  logic [2:0]     count;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];
  bit         sticky_exp = 0;
  bit         prod_done;

  alu_cmd_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out1(alu_out1), .alu_out2(alu_out2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .err_sticky(err_sticky), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b,
                                      logic [3:0] op);
    case (op[1:0])
      2'd0: return a | b;
      2'd1: return a & b;
      2'd2: return a - b;
      default: return a + b;
    endcase
  endfunction

  function automatic bit poison(logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  // Behavioural ALU driven by the DUT's head outputs
  always_comb begin
    alu_out1 = alu_f(alu_a, alu_b, alu_op);
    alu_out2 = poison(alu_op) ? alu_out1 : ~alu_out1;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Expected record: {err, out1, out2} from the command fields alone
  function automatic logic [8:0] expect_of(logic [3:0] a, logic [3:0] b,
                                           logic [3:0] op);
    logic [3:0] o1;
    o1 = alu_f(a, b, op);
    return {poison(op), o1, poison(op) ? o1 : ~o1};
  endfunction

  task automatic send(logic [3:0] a, logic [3:0] b, logic [3:0] op);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 500);
    if (acc) exp_q.push_back(expect_of(a, b, op));
    else chk("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
  endtask

  // Monitor: pops the scoreboard on every consumed result
  bit             prev_stall = 0;
  logic [2*W-1:0] prev_data;
  logic           prev_err;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("occupancy_ready", {count <= 3'(DEPTH), in_ready},
          {1'b1, count < 3'(DEPTH)});
      if (prev_stall) begin
        chk("stall_stable", {prev_err, prev_data}, {res_err, res_data});
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", {res_err, res_data}, 9'h1ff);
        end else begin
          e = exp_q.pop_front();
          if (e[8]) sticky_exp = 1;
          chk("result", {res_err, res_data}, e);
          chk("sticky", err_sticky, sticky_exp);
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_data = res_data;
      prev_err = res_err;
    end
  end

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();
    chk("rst_res_data", {res_err, res_data}, 0);
    @(posedge clk);
    #1;

    // 1: single add, latency check
    res_ready = 1'b1;
    send(4'd3, 4'd5, 4'd3);
    idle();
    @(negedge clk);
    chk("lat_alu_drive", {alu_a, alu_b, alu_op}, 12'h353);
    chk("lat_not_yet", res_valid, 0);
    @(negedge clk);
    chk("lat_res_valid", res_valid, 1);
    chk("lat_res_data", res_data, 8'h87);
    @(negedge clk);
    chk("t1_count", count, 0);
    @(posedge clk);
    #1;

    // 2: back-to-back
    send(4'd9, 4'd4, 4'd2);
    send(4'hC, 4'hA, 4'd1);
    send(4'hC, 4'hA, 4'd0);
    idle();
    drain();

    // 3: full / backpressure
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(4'(i + 1), 4'(i), 4'(i));
        idle();
        prod_done = 1;
      end
    join_none
    repeat (12) @(negedge clk);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_slot", res_valid, 1);
    chk("full_holds_first", res_data, {4'h1, 4'hE});
    chk("full_producer_held", prod_done, 0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait (prod_done);
    drain();

    // 4: wrap-around with toggling res_ready
    @(posedge clk);
    #1;
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(4'($urandom), 4'($urandom), 4'($urandom_range(0, 3)));
        idle();
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          res_ready = ~res_ready;
          @(posedge clk);
          #1;
        end
        res_ready = 1'b1;
      end
    join
    drain();

    // 5: invariant violation, then good results
    @(posedge clk);
    #1;
    send(4'h2, 4'h4, 4'h0);
    send(4'h2, 4'h4, 4'hC);
    send(4'h5, 4'h1, 4'h3);
    send(4'h7, 4'h3, 4'h1);
    idle();
    drain();
    chk("sticky_held", err_sticky, 1);

    // 6: reset mid-operation
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(4'(i), 4'hF, 4'h3);
    idle();
    repeat (2) @(negedge clk);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_valid", res_valid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    sticky_exp = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state();
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stale_valid", res_valid, 0);
    @(posedge clk);
    #1;

    // Randomised stream with random backpressure and poisoned ops
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(4'($urandom), 4'($urandom), 4'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        idle();
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          res_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        res_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
